// File: rtl/motor_pkg.sv
// motor_pkg: shared types and helpers for the motor_array_ctrl slice.
//   motor_state_e : per-channel FSM state (IDLE, RUN, DEAD)
//   STATE_W       : width of the encoded state (debug bus slice per channel)
//   dead_cnt_w()  : dead-time counter width, never below one bit
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } motor_state_e;

  localparam int STATE_W = 2;

  // $clog2(DEAD_TIME+1) is zero when DEAD_TIME is zero; keep one bit so the
  // counter declaration stays legal.
  function automatic int dead_cnt_w(input int dead_time);
    return ($clog2(dead_time + 1) < 1) ? 1 : $clog2(dead_time + 1);
  endfunction

endpackage

// File: rtl/motor_array_ctrl_if.sv
// motor_array_ctrl_if: board-side signal bundle of the motor controller.
//   SW        : per-channel direction request (1 = reverse)
//   BTN       : per-channel run request
//   DUTY      : per-channel duty, channel i at [i*PWM_W +: PWM_W]
//   MOTOR_EN  : H-bridge enable (PWM), registered
//   MOTOR_DIR : H-bridge direction, registered
//   LED       : {run flags, MOTOR_DIR}
//   STATE_DBG : per-channel FSM state, channel i at [i*STATE_W +: STATE_W]
// Modports: master = switch/button side (drives requests), slave = controller.
// Handshake: none. All signals are levels, sampled or updated on every rising
// clock edge; there is no valid/ready pair and no back-pressure.
interface motor_array_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 8
);
  import motor_pkg::*;

  logic [NUM_CH-1:0]         SW;
  logic [NUM_CH-1:0]         BTN;
  logic [NUM_CH*PWM_W-1:0]   DUTY;
  logic [NUM_CH-1:0]         MOTOR_EN;
  logic [NUM_CH-1:0]         MOTOR_DIR;
  logic [2*NUM_CH-1:0]       LED;
  logic [NUM_CH*STATE_W-1:0] STATE_DBG;

  modport master (
    output SW, BTN, DUTY,
    input  MOTOR_EN, MOTOR_DIR, LED, STATE_DBG
  );

  modport slave (
    input  SW, BTN, DUTY,
    output MOTOR_EN, MOTOR_DIR, LED, STATE_DBG
  );
endinterface

// File: rtl/motor_channel.sv
// motor_channel: one motor channel -- IDLE/RUN/DEAD FSM, dead-time counter,
// effective duty register and registered H-bridge outputs.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   sw, btn   : direction and run requests
//   duty      : requested duty
//   pwm_cnt   : shared free-running PWM counter from the top
//   motor_en  : registered PWM enable
//   motor_dir : registered direction
//   run       : channel is in RUN (registered state)
//   state     : FSM state for debug
// Build option: MOTOR_RAMP_EN enables soft start (duty_eff climbs by one per
// PWM period, is held at zero outside RUN, and decreases apply at once).
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int DEAD_TIME = 124999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw,
  input  logic             btn,
  input  logic [PWM_W-1:0] duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             motor_en,
  output logic             motor_dir,
  output logic             run,
  output motor_state_e     state
);

  localparam int             DW        = dead_cnt_w(DEAD_TIME);
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_TIME);

  motor_state_e     state_q, state_d;
  logic             dir_q, dir_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic [PWM_W-1:0] duty_eff_q, duty_eff_d;
  logic             en_q, en_d;

  // Next state / direction / dead counter. A direction mismatch always wins
  // over the run request; DEAD cannot be aborted or restarted.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (sw != dir_q) begin
          state_d = DEAD;
          dead_d  = DEAD_LOAD;
        end else if (btn) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sw != dir_q) begin
          state_d = DEAD;
          dead_d  = DEAD_LOAD;
        end else if (!btn) begin
          state_d = IDLE;
        end
      end
      DEAD: begin
        if (dead_q == '0) begin
          // Direction is taken from SW as seen on the expiry cycle.
          dir_d   = sw;
          state_d = btn ? RUN : IDLE;
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Effective duty changes only at the period boundary. The compare uses the
  // value in force for the current period, boundary cycle included, so every
  // period sees a single duty value.
  always_comb begin
    duty_eff_d = duty_eff_q;
`ifdef MOTOR_RAMP_EN
    if (state_q != RUN) begin
      duty_eff_d = '0;
    end else if (pwm_cnt == '0) begin
      duty_eff_d = (duty_eff_q < duty) ? duty_eff_q + PWM_W'(1) : duty;
    end
`else
    if (pwm_cnt == '0) begin
      duty_eff_d = duty;
    end
`endif
    en_d = (state_q == RUN) && (pwm_cnt < duty_eff_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      dead_q     <= '0;
      duty_eff_q <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      dead_q     <= dead_d;
      duty_eff_q <= duty_eff_d;
      en_q       <= en_d;
    end
  end

  assign motor_en  = en_q;
  assign motor_dir = dir_q;
  assign run       = (state_q == RUN);
  assign state     = state_q;

endmodule

// File: rtl/motor_array_ctrl.sv
// motor_array_ctrl: NUM_CH-channel brushed-DC motor controller with PWM speed
// control and a direction-reversal dead time.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : motor_array_ctrl_if.slave (SW, BTN, DUTY in; MOTOR_EN,
//              MOTOR_DIR, LED, STATE_DBG out)
// Parameters: NUM_CH (1..16), PWM_W (period = 2^PWM_W cycles), DEAD_TIME
// (dead interval = DEAD_TIME+1 cycles).
// Build option: MOTOR_RAMP_EN (soft start, see motor_channel).
// The top owns the shared PWM counter and the LED mapping; channels are
// otherwise independent.
module motor_array_ctrl
  import motor_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PWM_W     = 8,
  parameter int DEAD_TIME = 124999999
) (
  input logic                CLK,
  input logic                RST,
  motor_array_ctrl_if.slave  bus
);

  logic [PWM_W-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]         en_vec;
  logic [NUM_CH-1:0]         dir_vec;
  logic [NUM_CH-1:0]         run_vec;
  logic [NUM_CH*STATE_W-1:0] state_vec;

  // Free-running counter; natural wrap from 2^PWM_W-1 to 0.
  always_comb pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_state_e ch_state;

    motor_channel #(
      .PWM_W    (PWM_W),
      .DEAD_TIME(DEAD_TIME)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .sw       (bus.SW[i]),
      .btn      (bus.BTN[i]),
      .duty     (bus.DUTY[i*PWM_W +: PWM_W]),
      .pwm_cnt  (pwm_cnt_q),
      .motor_en (en_vec[i]),
      .motor_dir(dir_vec[i]),
      .run      (run_vec[i]),
      .state    (ch_state)
    );

    assign state_vec[i*STATE_W +: STATE_W] = ch_state;
  end

  assign bus.MOTOR_EN  = en_vec;
  assign bus.MOTOR_DIR = dir_vec;
  assign bus.LED       = {run_vec, dir_vec};
  assign bus.STATE_DBG = state_vec;

endmodule

// File: tb/tb_motor_array_ctrl.sv
// tb_motor_array_ctrl: self-checking bench for motor_array_ctrl
// (NUM_CH=2, PWM_W=4, DEAD_TIME=4). A reference model predicts all outputs
// each cycle into a queue; a negedge monitor pops and compares. Directed
// checks cover duty counts, reversal timing, dead-time no-abort, reset and
// simultaneous BTN/SW, followed by randomized stimulus.
// Build option: MOTOR_RAMP_EN (the model follows the same define).
module tb_motor_array_ctrl;
  import motor_pkg::*;

  localparam int NUM_CH    = 2;
  localparam int PWM_W     = 4;
  localparam int DEAD_TIME = 4;
  localparam int PERIOD    = 1 << PWM_W;
  localparam int W         = 4 * NUM_CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_array_ctrl_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) bus ();

  motor_array_ctrl #(
    .NUM_CH   (NUM_CH),
    .PWM_W    (PWM_W),
    .DEAD_TIME(DEAD_TIME)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Direction reversal is tracked as a deadline (edge index at which the
  // dead interval ends) rather than a counter; PWM phase is edge index mod
  // the period.
  logic [W-1:0] exp_q[$];
  int m_n;
  bit m_run[NUM_CH];
  bit m_dir[NUM_CH];
  int m_dead_end[NUM_CH];
  int m_eff[NUM_CH];
  bit m_en[NUM_CH];

  always @(posedge clk) begin
    logic [W-1:0] e;
    int phase, d;
    bit was_run;
    if (rst) begin
      m_n = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c] = 0; m_dir[c] = 0; m_dead_end[c] = -1; m_eff[c] = 0; m_en[c] = 0;
      end
    end else begin
      phase = m_n % PERIOD;
      for (int c = 0; c < NUM_CH; c++) begin
        d = int'(bus.DUTY[c*PWM_W +: PWM_W]);
        was_run = m_run[c];
`ifdef MOTOR_RAMP_EN
        if (!was_run) m_eff[c] = 0;
        else if (phase == 0) m_eff[c] = (m_eff[c] < d) ? m_eff[c] + 1 : d;
`else
        if (phase == 0) m_eff[c] = d;
`endif
        m_en[c] = was_run && (phase < m_eff[c]);
        if (m_dead_end[c] >= 0) begin
          if (m_n == m_dead_end[c]) begin
            m_dir[c] = bus.SW[c];
            m_run[c] = bus.BTN[c];
            m_dead_end[c] = -1;
          end
        end else if (bus.SW[c] != m_dir[c]) begin
          m_dead_end[c] = m_n + DEAD_TIME + 1;
          m_run[c] = 0;
        end else begin
          m_run[c] = bus.BTN[c];
        end
      end
      m_n++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e[c]            = m_en[c];
      e[NUM_CH + c]   = m_dir[c];
      e[2*NUM_CH + c] = m_dir[c];
      e[3*NUM_CH + c] = m_run[c];
    end
    exp_q.push_back(e);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.LED, bus.MOTOR_DIR, bus.MOTOR_EN};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL scoreboard t=%0t {LED,DIR,EN} got=%b exp=%b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ch(input int ch, input bit sw, input bit btn, input int duty);
    logic [PWM_W-1:0] dv;
    dv = PWM_W'(duty);
    bus.SW[ch]  = sw;
    bus.BTN[ch] = btn;
    bus.DUTY[ch*PWM_W +: PWM_W] = dv;
  endtask

  task automatic count_en0(output int cnt);
    cnt = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      cnt += int'(bus.MOTOR_EN[0]);
    end
  endtask

  task automatic wait_en0(output int ok);
    ok = 0;
    for (int k = 0; k < 64 && ok == 0; k++) begin
      @(negedge clk);
      if (bus.MOTOR_EN[0]) ok = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, ok, en_at2, dir_at, dead_cnt, sel, ch, st_k1;
    logic [PWM_W-1:0] rd;
    bus.SW = '0; bus.BTN = '0; bus.DUTY = '0;
    rst = 1'b1;
    wait_cyc(3);
    check("reset_en",  int'(bus.MOTOR_EN), 0);
    check("reset_led", int'(bus.LED), 0);
    rst = 1'b0;

    // PWM duty counts on ch0
    drive_ch(0, 0, 1, 5);
    wait_cyc(17 * PERIOD);
    count_en0(cnt); check("pwm_duty5", cnt, 5);
    drive_ch(0, 0, 1, 0);
    wait_cyc(17 * PERIOD);
    count_en0(cnt); check("pwm_duty0", cnt, 0);
    drive_ch(0, 0, 1, PERIOD - 1);
    wait_cyc(17 * PERIOD);
    count_en0(cnt); check("pwm_duty15", cnt, PERIOD - 1);

    // Reversal on ch0 with ch1 running as bystander
    drive_ch(1, 0, 1, 7);
    wait_cyc(40);
    bus.SW[0] = 1'b1;
    en_at2 = 1; dir_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) en_at2 = int'(bus.MOTOR_EN[0]);
      if (dir_at < 0 && bus.MOTOR_DIR[0]) dir_at = k;
    end
    check("rev_en_off", en_at2, 0);
    check("rev_dir_latency", dir_at, DEAD_TIME + 2);
    check("rev_ch1_dir", int'(bus.MOTOR_DIR[1]), 0);
    check("rev_ch1_run", int'(bus.LED[NUM_CH + 1]), 1);
    wait_en0(ok);
    check("rev_en_resume", ok, 1);

    // Dead time cannot be aborted: SW away and back during DEAD
    @(negedge clk);
    bus.SW[0] = 1'b0;
    dead_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.STATE_DBG[STATE_W-1:0] == DEAD) dead_cnt++;
      if (k == 2) bus.SW[0] = 1'b1;
    end
    check("noabort_dead_len", dead_cnt, DEAD_TIME + 1);
    check("noabort_dir", int'(bus.MOTOR_DIR[0]), 1);
    check("noabort_run", int'(bus.STATE_DBG[STATE_W-1:0]), int'(RUN));

    // Reset mid-RUN with EN high
    wait_en0(ok);
    check("rst_pre_en", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_en",  int'(bus.MOTOR_EN), 0);
    check("rst_dir", int'(bus.MOTOR_DIR), 0);
    check("rst_led", int'(bus.LED), 0);
    rst = 1'b0;

    // Simultaneous BTN and SW on idle ch1
    drive_ch(1, 0, 0, 7);
    wait_cyc(3);
    bus.BTN[1] = 1'b1; bus.SW[1] = 1'b1;
    st_k1 = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) st_k1 = int'(bus.STATE_DBG[STATE_W +: STATE_W]);
    end
    check("simul_dead_first", st_k1, int'(DEAD));
    check("simul_dir", int'(bus.MOTOR_DIR[1]), 1);
    check("simul_run", int'(bus.STATE_DBG[STATE_W +: STATE_W]), int'(RUN));

    // Randomized stimulus
    for (int it = 0; it < 150; it++) begin
      ch  = $urandom_range(0, NUM_CH - 1);
      sel = $urandom_range(0, 9);
      if (sel < 3) bus.BTN[ch] = ~bus.BTN[ch];
      else if (sel < 5) bus.SW[ch] = ~bus.SW[ch];
      else if (sel < 9) begin
        rd = PWM_W'($urandom_range(0, PERIOD - 1));
        bus.DUTY[ch*PWM_W +: PWM_W] = rd;
      end else begin
        rst = 1'b1;
        wait_cyc($urandom_range(1, 2));
        rst = 1'b0;
      end
      wait_cyc($urandom_range(1, 30));
    end

    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
